// File: rtl/alu_result_deserializer_if.sv
// Serial response line from the ALU plus the decoded result bus towards the monitor.
interface alu_result_deserializer_if;
  logic        sout;
  logic        res_valid;
  logic [31:0] res_c;
  logic [3:0]  res_flags;
  logic        res_crc_ok;
  logic        res_err;
  logic [5:0]  res_err_flags;
  logic        res_parity_ok;
  logic        frame_err;

  modport master (
    output sout,
    input  res_valid, res_c, res_flags, res_crc_ok, res_err,
    input  res_err_flags, res_parity_ok, frame_err
  );

  modport slave (
    input  sout,
    output res_valid, res_c, res_flags, res_crc_ok, res_err,
    output res_err_flags, res_parity_ok, frame_err
  );
endinterface

// File: rtl/alu_result_deserializer.sv
// Decodes ALU serial response frames (4 DATA + CTL, or a single error CTL) into
// a one-cycle result pulse with CRC/parity status; framing faults pulse frame_err.
module alu_result_deserializer #(
  parameter int unsigned GAP_MAX = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  alu_result_deserializer_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_GAP,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        type_q, type_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] c_q, c_d;
  logic [31:0] gap_q, gap_d;

  logic        res_valid_q, res_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] res_c_q, res_c_d;
  logic [3:0]  res_flags_q, res_flags_d;
  logic        res_crc_ok_q, res_crc_ok_d;
  logic        res_err_q, res_err_d;
  logic [5:0]  res_err_flags_q, res_err_flags_d;
  logic        res_parity_ok_q, res_parity_ok_d;

  // CRC3 (x^3+x+1) over {C, 1'b0, flags}, MSB first, evaluated once the CTL byte is in.
  function automatic logic [2:0] crc3(input logic [36:0] v);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = v[36-i] ^ c[2];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  logic [2:0] crc_calc;
  assign crc_calc = crc3({c_q, 1'b0, byte_q[6:3]});

  always_comb begin
    state_d         = state_q;
    bitcnt_d        = bitcnt_q;
    byte_d          = byte_q;
    type_d          = type_q;
    n_d             = n_q;
    c_d             = c_q;
    gap_d           = gap_q;
    res_valid_d     = 1'b0;
    frame_err_d     = 1'b0;
    res_c_d         = res_c_q;
    res_flags_d     = res_flags_q;
    res_crc_ok_d    = res_crc_ok_q;
    res_err_d       = res_err_q;
    res_err_flags_d = res_err_flags_q;
    res_parity_ok_d = res_parity_ok_q;

    unique case (state_q)
      S_IDLE: begin
        n_d   = '0;
        c_d   = '0;
        gap_d = '0;
        if (!bus.sout) state_d = S_TYPE;
      end
      S_TYPE: begin
        type_d   = bus.sout;
        bitcnt_d = 3'd7;
        state_d  = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        byte_d   = {byte_q[6:0], bus.sout};
        bitcnt_d = bitcnt_q - 3'd1;
        if (bitcnt_q == 3'd0) state_d = S_STOP;
      end
      S_STOP: begin
        gap_d = '0;
        if (!bus.sout) begin
          frame_err_d = 1'b1;
        end else if (!type_q) begin
          if (n_q != 3'd4) begin
            c_d     = {c_q[23:0], byte_q};
            n_d     = n_q + 3'd1;
            state_d = S_GAP;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (!byte_q[7]) begin
          if (n_q == 3'd4) begin
            res_valid_d     = 1'b1;
            res_c_d         = c_q;
            res_flags_d     = byte_q[6:3];
            res_crc_ok_d    = (crc_calc == byte_q[2:0]);
            res_err_d       = 1'b0;
            res_err_flags_d = '0;
            res_parity_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (n_q == 3'd0) begin
            res_valid_d     = 1'b1;
            res_c_d         = '0;
            res_flags_d     = '0;
            res_crc_ok_d    = 1'b1;
            res_err_d       = 1'b1;
            res_err_flags_d = byte_q[6:1];
            res_parity_ok_d = ~(^byte_q);
          end else begin
            frame_err_d = 1'b1;
          end
        end
        if (res_valid_d) state_d = S_DONE;
      end
      S_GAP: begin
        if (!bus.sout) begin
          gap_d   = '0;
          state_d = S_TYPE;
        end else if (GAP_MAX != 0 && gap_q == 32'(GAP_MAX - 1)) begin
          frame_err_d = 1'b1;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_DONE: begin
        n_d     = '0;
        c_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any framing fault drops the partial response and re-hunts for a start bit.
    if (frame_err_d) begin
      state_d = S_IDLE;
      n_d     = '0;
      c_d     = '0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      bitcnt_q        <= '0;
      byte_q          <= '0;
      type_q          <= 1'b0;
      n_q             <= '0;
      c_q             <= '0;
      gap_q           <= '0;
      res_valid_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      res_c_q         <= '0;
      res_flags_q     <= '0;
      res_crc_ok_q    <= 1'b0;
      res_err_q       <= 1'b0;
      res_err_flags_q <= '0;
      res_parity_ok_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bitcnt_q        <= bitcnt_d;
      byte_q          <= byte_d;
      type_q          <= type_d;
      n_q             <= n_d;
      c_q             <= c_d;
      gap_q           <= gap_d;
      res_valid_q     <= res_valid_d;
      frame_err_q     <= frame_err_d;
      res_c_q         <= res_c_d;
      res_flags_q     <= res_flags_d;
      res_crc_ok_q    <= res_crc_ok_d;
      res_err_q       <= res_err_d;
      res_err_flags_q <= res_err_flags_d;
      res_parity_ok_q <= res_parity_ok_d;
    end
  end

  assign bus.res_valid     = res_valid_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.res_c         = res_c_q;
  assign bus.res_flags     = res_flags_q;
  assign bus.res_crc_ok    = res_crc_ok_q;
  assign bus.res_err       = res_err_q;
  assign bus.res_err_flags = res_err_flags_q;
  assign bus.res_parity_ok = res_parity_ok_q;

endmodule

// File: tb/tb_alu_result_deserializer.sv
// Directed stimulus for alu_result_deserializer with a queue scoreboard of expected responses.
module tb_alu_result_deserializer;

  logic clk;
  logic rst_n;

  alu_result_deserializer_if bus ();

  alu_result_deserializer #(.GAP_MAX(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_ferr;
    logic [31:0] c;
    logic [3:0]  flags;
    logic        crc_ok;
    logic        err;
    logic [5:0]  eflags;
    logic        par;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] fl);
    logic [36:0] v;
    logic [2:0]  r;
    logic        fb;
    v = {c, 1'b0, fl};
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = v[i] ^ r[2];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  // Monitor: every result or framing pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.res_valid || bus.frame_err)) begin
      exp_t e;
      chk("valid_ferr_exclusive", {63'd0, bus.res_valid & bus.frame_err}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", {62'd0, bus.res_valid, bus.frame_err}, 64'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_ferr) begin
          chk("ferr_event", {62'd0, bus.res_valid, bus.frame_err}, 64'd1);
        end else begin
          chk("valid_event", {62'd0, bus.res_valid, bus.frame_err}, 64'd2);
          chk("res_c", {32'd0, bus.res_c}, {32'd0, e.c});
          chk("res_flags", {60'd0, bus.res_flags}, {60'd0, e.flags});
          chk("res_crc_ok", {63'd0, bus.res_crc_ok}, {63'd0, e.crc_ok});
          chk("res_err", {63'd0, bus.res_err}, {63'd0, e.err});
          chk("res_err_flags", {58'd0, bus.res_err_flags}, {58'd0, e.eflags});
          chk("res_parity_ok", {63'd0, bus.res_parity_ok}, {63'd0, e.par});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.sout = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] b, input logic stp);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stp);
  endtask

  task automatic push_ferr();
    exp_t e;
    e = '{is_ferr: 1'b1, c: '0, flags: '0, crc_ok: 1'b0, err: 1'b0, eflags: '0, par: 1'b0};
    sb.push_back(e);
  endtask

  task automatic expect_pulse(input string tag, input logic [1:0] exp_vf);
    chk(tag, {62'd0, bus.res_valid, bus.frame_err}, {62'd0, exp_vf});
  endtask

  task automatic send_data_frame(input logic [31:0] c, input logic [3:0] fl,
                                 input logic [2:0] crc, input int gap_after2);
    exp_t e;
    e = '{is_ferr: 1'b0, c: c, flags: fl, crc_ok: (crc == crc_model(c, fl)),
          err: 1'b0, eflags: '0, par: 1'b1};
    sb.push_back(e);
    send_pkt(1'b0, c[31:24], 1'b1);
    send_pkt(1'b0, c[23:16], 1'b1);
    idle(gap_after2);
    send_pkt(1'b0, c[15:8], 1'b1);
    send_pkt(1'b0, c[7:0], 1'b1);
    send_pkt(1'b1, {1'b0, fl, crc}, 1'b1);
    expect_pulse("data_latency", 2'b10);
    idle(1);
  endtask

  task automatic send_err_frame(input logic [7:0] b);
    exp_t e;
    e = '{is_ferr: 1'b0, c: '0, flags: '0, crc_ok: 1'b1, err: 1'b1,
          eflags: b[6:1], par: ~(^b)};
    sb.push_back(e);
    send_pkt(1'b1, b, 1'b1);
    expect_pulse("err_latency", 2'b10);
    idle(1);
  endtask

  logic [46:0] all_out;
  assign all_out = {bus.res_c, bus.res_flags, bus.res_crc_ok, bus.res_err,
                    bus.res_err_flags, bus.res_parity_ok, bus.res_valid, bus.frame_err};

  initial begin
    rst_n    = 1'b0;
    bus.sout = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {17'd0, all_out}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Zero result with matching and with corrupted CRC
    send_data_frame(32'h0000_0000, 4'b0000, 3'b000, 0);
    send_data_frame(32'h0000_0000, 4'b0000, 3'b001, 0);

    // Error responses, even and odd parity
    send_err_frame(8'hC9);
    send_err_frame(8'hC8);
    idle(3);

    // Bad stop bit in 2nd packet, then a clean frame
    push_ferr();
    send_pkt(1'b0, 8'h12, 1'b1);
    send_pkt(1'b0, 8'h34, 1'b0);
    expect_pulse("bad_stop", 2'b01);
    idle(2);
    send_data_frame(32'h1234_5678, 4'b1010, crc_model(32'h1234_5678, 4'b1010), 0);

    // Only 3 DATA packets before the data CTL
    push_ferr();
    send_pkt(1'b0, 8'hAA, 1'b1);
    send_pkt(1'b0, 8'hBB, 1'b1);
    send_pkt(1'b0, 8'hCC, 1'b1);
    send_pkt(1'b1, 8'h05, 1'b1);
    expect_pulse("short_data", 2'b01);
    idle(2);

    // Fifth DATA packet
    push_ferr();
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'h11, 1'b1);
    expect_pulse("fifth_data", 2'b01);
    idle(2);

    // Error CTL after data packets
    push_ferr();
    send_pkt(1'b0, 8'h77, 1'b1);
    send_pkt(1'b1, 8'hC9, 1'b1);
    expect_pulse("err_after_data", 2'b01);
    idle(2);

    // 63 idle cycles between packets is tolerated
    send_data_frame(32'hDEAD_BEEF, 4'b0110, crc_model(32'hDEAD_BEEF, 4'b0110), 63);
    idle(4);
    chk("hold_res_c", {32'd0, bus.res_c}, {32'd0, 32'hDEAD_BEEF});

    // 64 idle cycles between packets times out
    push_ferr();
    send_pkt(1'b0, 8'h01, 1'b1);
    idle(63);
    expect_pulse("gap_63_quiet", 2'b00);
    idle(1);
    expect_pulse("gap_64_timeout", 2'b01);
    idle(2);

    // sout stuck low: every 11 bits form a packet with a missing stop bit
    push_ferr();
    push_ferr();
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    expect_pulse("stuck_low_1", 2'b01);
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    expect_pulse("stuck_low_2", 2'b01);
    idle(3);

    // Reset for one cycle inside the 3rd packet
    send_pkt(1'b0, 8'h9A, 1'b1);
    send_pkt(1'b0, 8'hBC, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    send_bit(1'b1);
    chk("midframe_reset_outputs", {17'd0, all_out}, 64'd0);
    rst_n = 1'b1;
    idle(2);
    send_data_frame(32'hFFFF_FFFF, 4'b1001, crc_model(32'hFFFF_FFFF, 4'b1001), 0);

    idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
